// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: frame-synchronous 8-bit PWM for one tri-colour LED.
// Define RGB_PWM_FADE_EN to ramp duties by one LSB per frame instead of jumping.
module rgb_pwm_driver #(
    parameter int PWM_DIV         = 4,
    parameter bit LED_ACTIVE_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] fft_red,
    input  logic [7:0] fft_green,
    input  logic [7:0] fft_blue,
    output logic       rgb_r,
    output logic       rgb_g,
    output logic       rgb_b,
    output logic       frame_start,
    output logic       settled
);
    localparam int   PW      = PWM_DIV > 1 ? $clog2(PWM_DIV) : 1;
    localparam logic OFF_LVL = !LED_ACTIVE_HIGH;
    typedef enum logic [1:0] {ST_OFF, ST_LOAD, ST_RUN} state_t;
    state_t        state_q;
    logic [PW-1:0] pre_cnt_q;
    logic [7:0]    pwm_cnt_q, duty_r_q, duty_g_q, duty_b_q;
    logic [7:0]    duty_r_d, duty_g_d, duty_b_d;
    logic          rgb_r_q, rgb_g_q, rgb_b_q, frame_start_q, settled_q;
    logic          tick, frame_end;
    assign tick      = pre_cnt_q == PW'(PWM_DIV - 1);
    assign frame_end = tick && pwm_cnt_q == 8'd254;
    always_comb begin
`ifdef RGB_PWM_FADE_EN
        duty_r_d = duty_r_q < fft_red   ? duty_r_q + 8'd1 : duty_r_q > fft_red   ? duty_r_q - 8'd1 : duty_r_q;
        duty_g_d = duty_g_q < fft_green ? duty_g_q + 8'd1 : duty_g_q > fft_green ? duty_g_q - 8'd1 : duty_g_q;
        duty_b_d = duty_b_q < fft_blue  ? duty_b_q + 8'd1 : duty_b_q > fft_blue  ? duty_b_q - 8'd1 : duty_b_q;
`else
        duty_r_d = fft_red;
        duty_g_d = fft_green;
        duty_b_d = fft_blue;
`endif
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_OFF;
            pre_cnt_q     <= '0;
            pwm_cnt_q     <= 8'd0;
            duty_r_q      <= 8'd0;
            duty_g_q      <= 8'd0;
            duty_b_q      <= 8'd0;
            rgb_r_q       <= OFF_LVL;
            rgb_g_q       <= OFF_LVL;
            rgb_b_q       <= OFF_LVL;
            frame_start_q <= 1'b0;
            settled_q     <= 1'b1;
        end else begin
            settled_q     <= duty_r_q == fft_red && duty_g_q == fft_green && duty_b_q == fft_blue;
            frame_start_q <= 1'b0;
            rgb_r_q       <= OFF_LVL;
            rgb_g_q       <= OFF_LVL;
            rgb_b_q       <= OFF_LVL;
            case (state_q)
                ST_OFF: begin
                    pre_cnt_q <= '0;
                    pwm_cnt_q <= 8'd0;
                    if (enable) state_q <= ST_LOAD;
                end
                // LOAD behaves like a frame-end tick so the first frame is aligned like all others
                ST_LOAD: begin
                    pre_cnt_q <= '0;
                    pwm_cnt_q <= 8'd0;
                    if (!enable) state_q <= ST_OFF;
                    else begin
                        duty_r_q      <= duty_r_d;
                        duty_g_q      <= duty_g_d;
                        duty_b_q      <= duty_b_d;
                        frame_start_q <= 1'b1;
                        state_q       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_q   <= ST_OFF;
                        pre_cnt_q <= '0;
                        pwm_cnt_q <= 8'd0;
                    end else begin
                        rgb_r_q   <= (pwm_cnt_q < duty_r_q) ^ OFF_LVL;
                        rgb_g_q   <= (pwm_cnt_q < duty_g_q) ^ OFF_LVL;
                        rgb_b_q   <= (pwm_cnt_q < duty_b_q) ^ OFF_LVL;
                        pre_cnt_q <= tick ? '0 : pre_cnt_q + 1'b1;
                        if (tick) pwm_cnt_q <= frame_end ? 8'd0 : pwm_cnt_q + 8'd1;
                        if (frame_end) begin
                            duty_r_q      <= duty_r_d;
                            duty_g_q      <= duty_g_d;
                            duty_b_q      <= duty_b_d;
                            frame_start_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_OFF;
            endcase
        end
    end
    assign rgb_r       = rgb_r_q;
    assign rgb_g       = rgb_g_q;
    assign rgb_b       = rgb_b_q;
    assign frame_start = frame_start_q;
    assign settled     = settled_q;
endmodule
